// File: rtl/or_reduce_acc_if.sv
// Beat-in / result-out bundle for or_reduce_acc.
// OUT_BEATS exists only when OR_REDUCE_ACC_BEATCNT_EN is defined.
interface or_reduce_acc_if #(
   parameter int N_IN  = 3,
   parameter int WIDTH = 8
);
   logic                  IN_VALID;
   logic                  IN_READY;
   logic [N_IN*WIDTH-1:0] IN_DATA;
   logic                  IN_LAST;
   logic [1:0]            MODE;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [WIDTH-1:0]      OUT_DATA;
   logic                  OUT_ANY;
`ifdef OR_REDUCE_ACC_BEATCNT_EN
   logic [7:0]            OUT_BEATS;
`endif

   modport master (
      output IN_VALID, IN_DATA, IN_LAST, MODE, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, OUT_ANY
`ifdef OR_REDUCE_ACC_BEATCNT_EN
      , input OUT_BEATS
`endif
   );

   modport slave (
      input  IN_VALID, IN_DATA, IN_LAST, MODE, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, OUT_ANY
`ifdef OR_REDUCE_ACC_BEATCNT_EN
      , output OUT_BEATS
`endif
   );
endinterface

// File: rtl/or_reduce_acc.sv
// Lane-wise OR/AND/XOR reduction accumulated over an IN_LAST-delimited frame.
// Optional beat counter on OUT_BEATS: define OR_REDUCE_ACC_BEATCNT_EN.
module or_reduce_acc #(
   parameter int N_IN  = 3,
   parameter int WIDTH = 8
) (
   input logic         CLK,
   input logic         RST_N,
   or_reduce_acc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [1:0]       eff_mode;
   logic [WIDTH-1:0] red;
   logic             any_q;
   logic             accept;

   function automatic logic [WIDTH-1:0] op(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       m);
      case (m)
         2'b01:   op = a & b;
         2'b10:   op = a ^ b;
         default: op = a | b;
      endcase
   endfunction

   assign accept = bus.IN_VALID && (state != HOLD);

   // The first beat of a frame uses the live MODE; later beats use the latched one.
   always_comb begin
      eff_mode = (state == IDLE) ? bus.MODE : mode_q;
      red      = bus.IN_DATA[WIDTH-1:0];
      for (int k = 1; k < N_IN; k++)
         red = op(red, bus.IN_DATA[k*WIDTH +: WIDTH], eff_mode);
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      mode_nxt  = mode_q;
      case (state)
         IDLE: if (accept) begin
            mode_nxt  = bus.MODE;
            acc_nxt   = red;
            state_nxt = bus.IN_LAST ? HOLD : ACCUM;
         end
         ACCUM: if (accept) begin
            acc_nxt   = op(acc, red, mode_q);
            state_nxt = bus.IN_LAST ? HOLD : ACCUM;
         end
         HOLD: if (bus.OUT_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= IDLE;
         acc    <= '0;
         mode_q <= 2'b00;
         any_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         mode_q <= mode_nxt;
         any_q  <= |acc_nxt;
      end
   end

   assign bus.IN_READY  = (state != HOLD);
   assign bus.OUT_VALID = (state == HOLD);
   assign bus.OUT_DATA  = acc;
   assign bus.OUT_ANY   = any_q;

`ifdef OR_REDUCE_ACC_BEATCNT_EN
   logic [7:0] beats;

   always_ff @(posedge CLK) begin
      if (!RST_N)
         beats <= 8'd0;
      else if (accept)
         beats <= (state == IDLE) ? 8'd1 : ((beats == 8'hFF) ? beats : beats + 8'd1);
   end

   assign bus.OUT_BEATS = beats;
`endif
endmodule
